// File: rtl/xdatabus_router_pkg.sv
// ---------------------------------------------------------------------------
// xdatabus_router_pkg : shared FSM encoding, error data default, mask helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package xdatabus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Clears the low 'aw' bits; widths of 64 or more give an all-zero mask.
  function automatic logic [63:0] base_mask(input int unsigned aw);
    base_mask = ~((64'd1 << aw) - 64'd1);
  endfunction

  function automatic int sel_width(input int n);
    sel_width = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xdatabus_router_addr_match.sv
// ---------------------------------------------------------------------------
// xdatabus_router_addr_match : parallel base/width comparators, lowest index wins
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xdatabus_router_addr_match
  import xdatabus_router_pkg::*;
#(
  parameter int                     ADDR_W   = 32,
  parameter int                     NSLV     = 2,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*8-1:0]      SLV_AW   = '0
) (
  input  logic [ADDR_W-1:0]          addr_i,
  output logic                       hit_o,
  output logic [sel_width(NSLV)-1:0] sel_o
);

  localparam int SEL_W = sel_width(NSLV);

  logic [NSLV-1:0] w_hit;

  for (genvar i = 0; i < NSLV; i++) begin : g_cmp
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(base_mask(int'(SLV_AW[i*8 +: 8])));
    assign w_hit[i] = ((addr_i & MASK) == SLV_BASE[i*ADDR_W +: ADDR_W]);
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        hit_o = 1'b1;
        sel_o = SEL_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xdatabus_router.sv
// ---------------------------------------------------------------------------
// xdatabus_router : one master to NSLV slaves, req/ack handshake with timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xdatabus_router
  import xdatabus_router_pkg::*;
#(
  parameter int                     ADDR_W   = 32,
  parameter int                     DATA_W   = 32,
  parameter int                     NSLV     = 2,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'h0000_1000, 32'h0000_0000},
  parameter logic [NSLV*8-1:0]      SLV_AW   = {8'd12, 8'd12},
  parameter int                     TIMEOUT  = 256,
  parameter logic [DATA_W-1:0]      ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_req_i,
  input  logic                   m_wr_i,
  input  logic [ADDR_W-1:0]      m_addr_i,
  input  logic [DATA_W-1:0]      m_wdata_i,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic [DATA_W-1:0]      m_rdata_o,
  output logic                   m_busy_o,
  output logic [NSLV-1:0]        s_req_o,
  output logic                   s_wr_o,
  output logic [ADDR_W-1:0]      s_addr_o,
  output logic [DATA_W-1:0]      s_wdata_o,
  input  logic [NSLV-1:0]        s_ack_i,
  input  logic [NSLV*DATA_W-1:0] s_rdata_i
);

  localparam int                SEL_W   = sel_width(NSLV);
  localparam int                CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                w_hit;
  logic [SEL_W-1:0]    w_sel;
  logic [DATA_W-1:0]   w_slv_rdata;
  logic                w_timeout;

  xdatabus_router_addr_match #(
    .ADDR_W   (ADDR_W),
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_AW   (SLV_AW)
  ) u_match (
    .addr_i (m_addr_i),
    .hit_o  (w_hit),
    .sel_o  (w_sel)
  );

  assign w_slv_rdata = s_rdata_i[int'(sel_q)*DATA_W +: DATA_W];
  assign w_timeout   = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  assign m_ack_o   = (state_q == ST_RESP);
  assign m_err_o   = err_q;
  assign m_rdata_o = rdata_q;
  assign m_busy_o  = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    s_req_o   = '0;
    s_wr_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (m_req_i) begin
          if (w_hit) begin
            s_req_o[w_sel] = 1'b1;
            s_wr_o         = m_wr_i;
            s_addr_o       = m_addr_i;
            s_wdata_o      = m_wdata_i;
            sel_d          = w_sel;
            wr_d           = m_wr_i;
            cnt_d          = '0;
            state_d        = ST_WAIT;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (s_ack_i[sel_q]) begin
          err_d   = 1'b0;
          rdata_d = wr_q ? '0 : w_slv_rdata;
          state_d = ST_RESP;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          state_d = ST_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_xdatabus_router.sv
// ---------------------------------------------------------------------------
// tb_xdatabus_router : directed vectors with hand-computed expectations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_xdatabus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic        m_ack, m_err, m_busy;
  logic [31:0] m_rdata;
  logic [1:0]  s_req;
  logic        s_wr;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_ack;
  logic [63:0] s_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xdatabus_router #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NSLV     (2),
    .SLV_BASE ({32'h0000_1000, 32'h0000_0000}),
    .SLV_AW   ({8'd12, 8'd12}),
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req_i   (m_req),
    .m_wr_i    (m_wr),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_rdata_o (m_rdata),
    .m_busy_o  (m_busy),
    .s_req_o   (s_req),
    .s_wr_o    (s_wr),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_ack_i   (s_ack),
    .s_rdata_i (s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, well clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_rdata = '0;
    step(); step();
    #1;
    chk("rst_ack",   m_ack,   0);
    chk("rst_err",   m_err,   0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_busy",  m_busy,  0);
    chk("rst_sreq",  s_req,   0);
    step();
    rst = 1'b0;

    // 1: read slave 1, ack after a few WAIT cycles
    step();
    m_req = 1'b1; m_wr = 1'b0; m_addr = 32'h1004;
    #1;
    chk("t1_sreq",  s_req,  2'b10);
    chk("t1_saddr", s_addr, 32'h1004);
    chk("t1_swr",   s_wr,   0);
    chk("t1_idle",  m_busy, 0);
    step();
    m_req = 1'b0;
    #1;
    chk("t1_busy",  m_busy, 1);
    chk("t1_sreq0", s_req,  0);
    step(); step();
    s_ack = 2'b10; s_rdata = {32'h0000_1234, 32'h0000_0000};
    #1;
    chk("t1_noack", m_ack, 0);
    step();
    s_ack = '0;
    #1;
    chk("t1_ack",   m_ack,   1);
    chk("t1_err",   m_err,   0);
    chk("t1_rdata", m_rdata, 32'h1234);
    step();
    #1;
    chk("t1_ackoff", m_ack,   0);
    chk("t1_hold",   m_rdata, 32'h1234);
    chk("t1_free",   m_busy,  0);

    // 2: write slave 0, ack next cycle; write response carries zero data
    m_req = 1'b1; m_wr = 1'b1; m_addr = 32'h0008; m_wdata = 32'hA5A5;
    #1;
    chk("t2_sreq",   s_req,   2'b01);
    chk("t2_swr",    s_wr,    1);
    chk("t2_swdata", s_wdata, 32'hA5A5);
    step();
    m_req = 1'b0; m_wr = 1'b0;
    s_ack = 2'b01; s_rdata = {32'h5555_5555, 32'h7777_7777};
    #1;
    chk("t2_noack", m_ack, 0);
    step();
    s_ack = '0;
    #1;
    chk("t2_ack",   m_ack,   1);
    chk("t2_err",   m_err,   0);
    chk("t2_rdata", m_rdata, 0);
    step();

    // 3: unmapped read
    m_req = 1'b1; m_addr = 32'h8000;
    #1;
    chk("t3_sreq", s_req, 0);
    step();
    m_req = 1'b0;
    #1;
    chk("t3_ack",   m_ack,   1);
    chk("t3_err",   m_err,   1);
    chk("t3_rdata", m_rdata, 32'hDEADBEEF);
    step();
    #1;
    chk("t3_ackoff", m_ack,   0);
    chk("t3_erroff", m_err,   0);
    chk("t3_hold",   m_rdata, 32'hDEADBEEF);

    // 4: slave 0 never acks; response on cycle 9 after the request
    m_req = 1'b1; m_addr = 32'h0010;
    #1;
    chk("t4_sreq", s_req, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      step();
      m_req = 1'b0;
      #1;
      chk($sformatf("t4_wait%0d", k), m_ack, 0);
    end
    step();
    #1;
    chk("t4_ack",   m_ack,   1);
    chk("t4_err",   m_err,   1);
    chk("t4_rdata", m_rdata, 32'hDEADBEEF);
    step();
    s_ack = 2'b01; s_rdata = {32'h0, 32'h9999_9999};
    #1;
    chk("t4_late_sreq", s_req, 0);
    step();
    s_ack = '0;
    #1;
    chk("t4_late_ack", m_ack, 0);
    step();
    #1;
    chk("t4_late_ack2", m_ack,  0);
    chk("t4_late_busy", m_busy, 0);

    // 5: wrong-slave ack and a second request during WAIT are ignored
    m_req = 1'b1; m_addr = 32'h0020;
    #1;
    chk("t5_sreq", s_req, 2'b01);
    step();
    m_req = 1'b0;
    s_ack = 2'b10; s_rdata = {32'h0000_0BAD, 32'h0000_0000};
    step();
    s_ack = '0;
    #1;
    chk("t5_wrongack", m_ack,  0);
    chk("t5_busy",     m_busy, 1);
    m_req = 1'b1; m_addr = 32'h1000;
    #1;
    chk("t5_req2_sreq", s_req, 0);
    step();
    m_req = 1'b0;
    s_ack = 2'b01; s_rdata = {32'h0000_0BAD, 32'h0000_C0DE};
    #1;
    chk("t5_noack", m_ack, 0);
    step();
    s_ack = '0;
    #1;
    chk("t5_ack",   m_ack,   1);
    chk("t5_err",   m_err,   0);
    chk("t5_rdata", m_rdata, 32'hC0DE);
    step();
    #1;
    chk("t5_ackoff", m_ack, 0);
    step();
    #1;
    chk("t5_single", m_ack, 0);

    // 6: reset two cycles into WAIT, then a fresh request
    m_req = 1'b1; m_addr = 32'h1008;
    #1;
    chk("t6_sreq", s_req, 2'b10);
    step();
    m_req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("t6_busy",  m_busy,  0);
    chk("t6_ack",   m_ack,   0);
    chk("t6_err",   m_err,   0);
    chk("t6_rdata", m_rdata, 0);
    chk("t6_sreq0", s_req,   0);
    step();
    rst = 1'b0;
    s_ack = 2'b10; s_rdata = {32'h0000_0BAD, 32'h0};
    step();
    s_ack = '0;
    #1;
    chk("t6_late_ack", m_ack, 0);
    m_req = 1'b1; m_addr = 32'h1010;
    #1;
    chk("t6_new_sreq", s_req, 2'b10);
    step();
    m_req = 1'b0;
    s_ack = 2'b10; s_rdata = {32'h0000_5678, 32'h0};
    step();
    s_ack = '0;
    #1;
    chk("t6_new_ack",   m_ack,   1);
    chk("t6_new_err",   m_err,   0);
    chk("t6_new_rdata", m_rdata, 32'h5678);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
